// File: rtl/oflow_core_fsm_fe_pkg.sv
// Shared sizing and state encoding for the feature-extraction set sequencer.
package oflow_core_fsm_fe_pkg;

  localparam int PE_NUM          = 24;
  localparam int PE_LEN          = 5;
  localparam int SET_LEN         = 8;
  localparam int REMAIN_BBOX_LEN = 10;

  typedef enum logic [2:0] {
    idle_st       = 3'd0,
    wait_set_st   = 3'd1,
    fe_st         = 3'd2,
    set_done_st   = 3'd3,
    frame_done_st = 3'd4
  } fe_state_t;

endpackage

// File: rtl/oflow_core_fsm_fe_if.sv
// Bundle between the FE sequencer (slave) and its environment (master):
// top-FSM control, DMA set handshake and PE-array launch/completion.
interface oflow_core_fsm_fe_if;
  import oflow_core_fsm_fe_pkg::*;

  logic                       start_pe;
  logic [SET_LEN-1:0]         num_of_sets;
  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes;
  // A set transfers in the cycle where new_set && ready_new_set; the DMA
  // holds new_set (and the remain count stays valid) until that cycle.
  logic                       new_set;
  logic                       ready_new_set;
  logic                       start_fe;
  logic [PE_NUM-1:0]          pe_en;
  logic [PE_NUM-1:0]          done_fe;
  logic                       control_ready_new_set;
  logic [SET_LEN-1:0]         counter_set_fe;
  logic                       done_all_sets;

  modport slave (
    input  start_pe, num_of_sets, counter_of_remain_bboxes, new_set, done_fe,
    output ready_new_set, start_fe, pe_en, control_ready_new_set,
           counter_set_fe, done_all_sets
  );

  modport master (
    output start_pe, num_of_sets, counter_of_remain_bboxes, new_set, done_fe,
    input  ready_new_set, start_fe, pe_en, control_ready_new_set,
           counter_set_fe, done_all_sets
  );

endinterface

// File: rtl/oflow_core_fsm_fe_pe_mask_gen.sv
// Remaining-bbox count to PE enable mask; saturates at all ones once a full
// set's worth of bboxes remains.
module oflow_pe_mask_gen
  import oflow_core_fsm_fe_pkg::*;
(
  input  logic [REMAIN_BBOX_LEN-1:0] remain,
  output logic [PE_NUM-1:0]          mask
);

  localparam logic [PE_NUM-1:0] ONE = PE_NUM'(1);

  always_comb begin
    if (remain >= REMAIN_BBOX_LEN'(PE_NUM)) mask = '1;
    else                                    mask = (ONE << remain[PE_LEN-1:0]) - ONE;
  end

endmodule

// File: rtl/oflow_core_fsm_fe.sv
// Set-level FE sequencer: accepts DMA sets, enables the PEs holding valid
// bboxes, launches FE, gathers per-PE completion and reports to the top FSM.
module oflow_core_fsm_fe
  import oflow_core_fsm_fe_pkg::*;
(
  input  logic                clk,
  input  logic                reset_N,
  oflow_core_fsm_fe_if.slave  bus,
  output fe_state_t           fe_state
);

  fe_state_t          state_q, state_d;
  logic [PE_NUM-1:0]  mask;
  logic [PE_NUM-1:0]  pe_en_q;
  logic [PE_NUM-1:0]  collected_q, collected_nxt;
  logic [SET_LEN-1:0] num_sets_q;
  logic [SET_LEN-1:0] counter_set_q;
  logic               start_fe_q;
  logic               last_set;

  oflow_pe_mask_gen u_mask_gen (
    .remain (bus.counter_of_remain_bboxes),
    .mask   (mask)
  );

  // done_fe from disabled PEs never reaches the sticky collector.
  assign collected_nxt = collected_q | (bus.done_fe & pe_en_q);
  assign last_set      = (counter_set_q + SET_LEN'(1)) == num_sets_q;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state_q <= idle_st;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      idle_st:
        if (bus.start_pe) state_d = (bus.num_of_sets == '0) ? frame_done_st : wait_set_st;
      wait_set_st:
        if (bus.new_set) state_d = (mask == '0) ? set_done_st : fe_st;
      fe_st:
        if (collected_nxt == pe_en_q) state_d = set_done_st;
      set_done_st:
        state_d = last_set ? frame_done_st : wait_set_st;
      frame_done_st:
        state_d = idle_st;
      default:
        state_d = idle_st;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      pe_en_q       <= '0;
      collected_q   <= '0;
      num_sets_q    <= '0;
      counter_set_q <= '0;
      start_fe_q    <= 1'b0;
    end else begin
      start_fe_q <= 1'b0;
      case (state_q)
        idle_st:
          if (bus.start_pe) begin
            counter_set_q <= '0;
            num_sets_q    <= bus.num_of_sets;
          end
        wait_set_st:
          if (bus.new_set) begin
            pe_en_q     <= mask;
            collected_q <= '0;
            start_fe_q  <= (mask != '0);
          end
        fe_st:
          collected_q <= collected_nxt;
        set_done_st: begin
          counter_set_q <= counter_set_q + SET_LEN'(1);
          pe_en_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_new_set         = (state_q == wait_set_st);
  assign bus.control_ready_new_set = (state_q == set_done_st);
  assign bus.done_all_sets         = (state_q == frame_done_st);
  assign bus.start_fe              = start_fe_q;
  assign bus.pe_en                 = pe_en_q;
  assign bus.counter_set_fe        = counter_set_q;
  assign fe_state                  = state_q;

endmodule

// File: tb/tb_oflow_core_fsm_fe.sv
// Bench for oflow_core_fsm_fe: table of sets per frame plus hand-built
// corner sequences, with expected masks/counts queued at handshake time.
module tb_oflow_core_fsm_fe;
  import oflow_core_fsm_fe_pkg::*;

  logic      clk;
  logic      reset_N;
  fe_state_t fe_state;

  oflow_core_fsm_fe_if bus ();

  oflow_core_fsm_fe dut (
    .clk      (clk),
    .reset_N  (reset_N),
    .bus      (bus),
    .fe_state (fe_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ctrl   = 0;
  int n_done   = 0;
  int exp_ctrl_total = 0;
  int exp_done_total = 0;
  logic [PE_NUM-1:0]  exp_pe_q[$];
  logic [SET_LEN-1:0] exp_cnt_q[$];
  bit pend_cnt = 0;

  typedef struct {
    logic [REMAIN_BBOX_LEN-1:0] remain;
    logic [PE_NUM-1:0]          mask;
    bit                         at_once;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: mask popped on start_fe, set count popped the cycle after control_ready_new_set.
  always @(negedge clk) begin
    if (!reset_N) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt) begin
        if (exp_cnt_q.size() == 0) check("sb_cnt_underflow", exp_cnt_q.size(), 1);
        else check("counter_set_fe", 32'(bus.counter_set_fe), 32'(exp_cnt_q.pop_front()));
      end
      pend_cnt = bus.control_ready_new_set;
      if (bus.start_fe) begin
        if (exp_pe_q.size() == 0) check("sb_pe_underflow", exp_pe_q.size(), 1);
        else check("pe_en", 32'(bus.pe_en), 32'(exp_pe_q.pop_front()));
      end
      if (bus.control_ready_new_set) n_ctrl++;
      if (bus.done_all_sets) n_done++;
    end
  end

  task automatic do_start(input logic [SET_LEN-1:0] num);
    @(posedge clk); #1;
    bus.start_pe = 1'b1;
    bus.num_of_sets = num;
    @(posedge clk); #1;
    bus.start_pe = 1'b0;
  endtask

  task automatic handshake(input logic [REMAIN_BBOX_LEN-1:0] remain,
                           input logic [PE_NUM-1:0] exp_mask,
                           input logic [SET_LEN-1:0] exp_cnt);
    int t = 0;
    @(negedge clk);
    while (!bus.ready_new_set && t < 50) begin @(negedge clk); t++; end
    if (!bus.ready_new_set) check("ready_timeout", 32'(bus.ready_new_set), 1);
    bus.counter_of_remain_bboxes = remain;
    bus.new_set = 1'b1;
    if (exp_mask != '0) exp_pe_q.push_back(exp_mask);
    exp_cnt_q.push_back(exp_cnt);
    exp_ctrl_total++;
    @(posedge clk); #1;
    bus.new_set = 1'b0;
  endtask

  task automatic run_fe(input logic [PE_NUM-1:0] mask, input bit at_once,
                        input bit noise_en, input bit poke);
    logic [PE_NUM-1:0] noise;
    int remaining;
    int g;
    bit first;
    if (mask == '0) begin
      @(negedge clk);
      check("empty_no_start_fe", 32'(bus.start_fe), 0);
      check("empty_state", 32'(fe_state), 32'(set_done_st));
      return;
    end
    if (poke) bus.new_set = 1'b1;
    if (at_once) begin
      noise = noise_en ? PE_NUM'($urandom()) : '0;
      bus.done_fe = mask | (noise & ~mask);
      @(negedge clk);
      check("start_fe_lat1", 32'(bus.start_fe), 1);
      @(posedge clk); #1;
      bus.done_fe = '0;
      @(negedge clk);
      check("ctrl_2_after_hs", 32'(bus.control_ready_new_set), 1);
    end else begin
      remaining = $countones(mask);
      first = 1;
      for (int b = 0; b < PE_NUM; b++) begin
        if (mask[b]) begin
          noise = noise_en ? PE_NUM'($urandom()) : '0;
          bus.done_fe = (PE_NUM'(1) << b) | (noise & ~mask);
          remaining--;
          @(negedge clk);
          if (first) check("start_fe_lat1", 32'(bus.start_fe), 1);
          else       check("start_fe_once", 32'(bus.start_fe), 0);
          first = 0;
          check("not_done_early", 32'(fe_state), 32'(fe_st));
          if (poke) check("ready_low_in_fe", 32'(bus.ready_new_set), 0);
          @(posedge clk); #1;
          bus.done_fe = '0;
          if (remaining != 0) begin
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
          end
        end
      end
      bus.new_set = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_ctrl();
    int t = 0;
    while (!bus.control_ready_new_set && t < 100) begin @(negedge clk); t++; end
    check("ctrl_seen", 32'(bus.control_ready_new_set), 1);
  endtask

  task automatic do_set(input logic [REMAIN_BBOX_LEN-1:0] remain, input logic [PE_NUM-1:0] mask,
                        input bit at_once, input bit noise_en, input bit poke,
                        input logic [SET_LEN-1:0] cnt, input bit last);
    handshake(remain, mask, cnt);
    run_fe(mask, at_once, noise_en, poke);
    wait_ctrl();
    @(negedge clk);
    if (last) check("done_all_after_ctrl", 32'(bus.done_all_sets), 1);
    else      check("ready_again", 32'(bus.ready_new_set), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.ready_new_set), 0);
    check({tag, "_start_fe"}, 32'(bus.start_fe), 0);
    check({tag, "_pe_en"}, 32'(bus.pe_en), 0);
    check({tag, "_ctrl"}, 32'(bus.control_ready_new_set), 0);
    check({tag, "_cnt"}, 32'(bus.counter_set_fe), 0);
    check({tag, "_done_all"}, 32'(bus.done_all_sets), 0);
    check({tag, "_state"}, 32'(fe_state), 32'(idle_st));
  endtask

  initial begin
    int d0;
    int r0;
    vecs[0] = '{10'd48,   24'hFFFFFF, 1'b0};
    vecs[1] = '{10'd24,   24'hFFFFFF, 1'b1};
    vecs[2] = '{10'd23,   24'h7FFFFF, 1'b0};
    vecs[3] = '{10'd12,   24'h000FFF, 1'b1};
    vecs[4] = '{10'd5,    24'h00001F, 1'b0};
    vecs[5] = '{10'd1,    24'h000001, 1'b0};
    vecs[6] = '{10'd0,    24'h000000, 1'b0};
    vecs[7] = '{10'd1023, 24'hFFFFFF, 1'b1};

    reset_N = 1'b0;
    bus.start_pe = 1'b0;
    bus.num_of_sets = '0;
    bus.counter_of_remain_bboxes = '0;
    bus.new_set = 1'b0;
    bus.done_fe = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset_N = 1'b1;

    // Frame walking the table: one set per record.
    do_start(8'd8);
    for (int i = 0; i < 8; i++)
      do_set(vecs[i].remain, vecs[i].mask, vecs[i].at_once, 1'b1, 1'b0, 8'(i + 1), i == 7);
    exp_done_total++;

    // Partial set with noise on disabled PEs.
    do_start(8'd1);
    do_set(10'd5, 24'h00001F, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    exp_done_total++;

    // All completions land with start_fe.
    do_start(8'd1);
    do_set(10'd24, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
    exp_done_total++;

    // Stray start_pe in wait_set_st and new_set held during fe_st.
    do_start(8'd2);
    do_start(8'd7);
    @(negedge clk);
    check("ign_start_state", 32'(fe_state), 32'(wait_set_st));
    check("ign_start_cnt", 32'(bus.counter_set_fe), 0);
    do_set(10'd24, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
    do_set(10'd30, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1);
    exp_done_total++;

    // Reset in the middle of a set after 10 completions.
    do_start(8'd3);
    handshake(10'd48, 24'hFFFFFF, 8'd1);
    for (int b = 0; b < 10; b++) begin
      bus.done_fe = PE_NUM'(1) << b;
      @(posedge clk); #1;
      bus.done_fe = '0;
    end
    @(negedge clk);
    check("pre_reset_state", 32'(fe_state), 32'(fe_st));
    @(posedge clk); #1;
    reset_N = 1'b0;
    exp_cnt_q.delete();
    exp_ctrl_total--;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    reset_N = 1'b1;
    do_start(8'd1);
    do_set(10'd24, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
    exp_done_total++;

    // Empty frame.
    do_start(8'd0);
    d0 = 0;
    r0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done_all_sets) d0++;
      if (bus.ready_new_set) r0++;
    end
    check("zero_sets_done_all", d0, 1);
    check("zero_sets_ready", r0, 0);
    check("zero_sets_cnt", 32'(bus.counter_set_fe), 0);
    check("zero_sets_idle", 32'(fe_state), 32'(idle_st));
    exp_done_total++;

    repeat (2) @(negedge clk);
    check("total_ctrl_pulses", n_ctrl, exp_ctrl_total);
    check("total_done_all", n_done, exp_done_total);
    check("pe_q_drained", exp_pe_q.size(), 0);
    check("cnt_q_drained", exp_cnt_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
